// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: drives a 1-cycle-latency memory from an internal PC and
// splits each wide word into instructions streamed out on valid/ready. Optional: IFETCH_MISALIGN_FAULT_EN.
module ifetch_buffer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_WIDTH+$clog2(MEM_WIDTH/8)-1:0] RESET_PC = '0
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  output logic [ADDR_WIDTH-1:0]                       mem_addr,
  input  logic [MEM_WIDTH-1:0]                        mem_rdata,
  input  logic                                        redirect_valid,
  input  logic [ADDR_WIDTH+$clog2(MEM_WIDTH/8)-1:0]   redirect_pc,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [INSTR_WIDTH-1:0]                      out_instr,
  output logic [ADDR_WIDTH+$clog2(MEM_WIDTH/8)-1:0]   out_pc,
  output logic                                        out_fault
);

  localparam int LANES = MEM_WIDTH / INSTR_WIDTH;
  localparam int OFFS  = $clog2(MEM_WIDTH / 8);
  localparam int IB    = $clog2(INSTR_WIDTH / 8);
  localparam int PCW   = ADDR_WIDTH + OFFS;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1) + 1;

`ifdef IFETCH_MISALIGN_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef logic [PCW-1:0] pc_t;
  typedef logic [LW-1:0]  lane_t;
  typedef logic [PW-1:0]  ptr_t;
  typedef logic [CW-1:0]  cnt_t;

  function automatic pc_t word_base(input pc_t pc);
    return pc & ~pc_t'((1 << OFFS) - 1);
  endfunction

  function automatic lane_t lane_of(input pc_t pc);
    pc_t t;
    t = pc >> IB;
    return lane_t'(t) & lane_t'(LANES - 1);
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

  // Fetch-side state
  pc_t    fetch_pc_q, fetch_pc_d;
  logic   inflight_q, inflight_d;
  pc_t    infl_pc_q, infl_pc_d;
  lane_t  infl_lane_q, infl_lane_d;
  logic   halt_q, halt_d;
  logic   flt_req_q, flt_req_d;
  logic   flt_pend_q, flt_pend_d;
  pc_t    flt_pc_q, flt_pc_d;

  // FIFO bookkeeping and held output values
  cnt_t   count_q, count_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  logic [INSTR_WIDTH-1:0] last_instr_q, last_instr_d;
  pc_t    last_pc_q, last_pc_d;

  logic [MEM_WIDTH-1:0] data_q  [DEPTH];
  pc_t                  epc_q   [DEPTH];
  lane_t                lane_q  [DEPTH];
  logic                 fault_q [DEPTH];

  logic                   head_valid_s;
  lane_t                  head_lane_s;
  logic [INSTR_WIDTH-1:0] head_instr_s;
  pc_t                    head_pc_s;
  logic                   head_fault_s;
  logic                   xfer_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   room_s;
  logic                   issue_s;
  logic                   misalign_s;

  assign head_valid_s = (count_q != cnt_t'(0));
  assign head_lane_s  = lane_q[rd_ptr_q];
  assign head_fault_s = fault_q[rd_ptr_q];
  assign head_instr_s = data_q[rd_ptr_q][int'(head_lane_s) * INSTR_WIDTH +: INSTR_WIDTH];
  // Fault entries carry the raw redirect PC, so no lane offset is added for them.
  assign head_pc_s    = head_fault_s ? epc_q[rd_ptr_q]
                                     : epc_q[rd_ptr_q] + (pc_t'(head_lane_s) << IB);

  assign xfer_s     = head_valid_s && out_ready;
  assign pop_s      = xfer_s && (head_fault_s || (head_lane_s == lane_t'(LANES - 1)));
  assign push_s     = inflight_q || flt_pend_q;
  // The in-flight word already owns a slot, so counting it here rules out overflow.
  assign room_s     = (count_q + cnt_t'(inflight_q)) < cnt_t'(DEPTH);
  assign issue_s    = !redirect_valid && !halt_q && room_s;
  assign misalign_s = FAULT_EN && (redirect_pc[IB-1:0] != '0);

  assign mem_addr  = fetch_pc_q[PCW-1:OFFS];
  assign out_valid = head_valid_s;
  assign out_instr = head_valid_s ? head_instr_s : last_instr_q;
  assign out_pc    = head_valid_s ? head_pc_s : last_pc_q;
  assign out_fault = FAULT_EN && head_valid_s && head_fault_s;

  // Next-state computation for fetch and FIFO control
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inflight_d   = inflight_q;
    infl_pc_d    = infl_pc_q;
    infl_lane_d  = infl_lane_q;
    halt_d       = halt_q;
    flt_req_d    = flt_req_q;
    flt_pend_d   = flt_pend_q;
    flt_pc_d     = flt_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;

    if (head_valid_s) begin
      last_instr_d = head_instr_s;
      last_pc_d    = head_pc_s;
    end else begin
      last_instr_d = last_instr_q;
      last_pc_d    = last_pc_q;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~pc_t'((1 << IB) - 1);
      inflight_d = 1'b0;
      count_d    = cnt_t'(0);
      rd_ptr_d   = ptr_t'(0);
      wr_ptr_d   = ptr_t'(0);
      halt_d     = misalign_s;
      flt_req_d  = misalign_s;
      flt_pend_d = 1'b0;
      flt_pc_d   = redirect_pc;
    end else begin
      inflight_d = issue_s;
      flt_req_d  = 1'b0;
      flt_pend_d = flt_req_q;
      if (issue_s) begin
        fetch_pc_d  = word_base(fetch_pc_q) + pc_t'(MEM_WIDTH / 8);
        infl_pc_d   = word_base(fetch_pc_q);
        infl_lane_d = lane_of(fetch_pc_q);
      end else begin
        fetch_pc_d  = fetch_pc_q;
      end
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + cnt_t'(push_s) - cnt_t'(pop_s);
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      inflight_q   <= 1'b0;
      infl_pc_q    <= pc_t'(0);
      infl_lane_q  <= lane_t'(0);
      halt_q       <= 1'b0;
      flt_req_q    <= 1'b0;
      flt_pend_q   <= 1'b0;
      flt_pc_q     <= pc_t'(0);
      count_q      <= cnt_t'(0);
      rd_ptr_q     <= ptr_t'(0);
      wr_ptr_q     <= ptr_t'(0);
      last_instr_q <= '0;
      last_pc_q    <= pc_t'(0);
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      infl_pc_q    <= infl_pc_d;
      infl_lane_q  <= infl_lane_d;
      halt_q       <= halt_d;
      flt_req_q    <= flt_req_d;
      flt_pend_q   <= flt_pend_d;
      flt_pc_q     <= flt_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset is needed
  always_ff @(posedge clk) begin
    if (reset_n && !redirect_valid && push_s) begin
      data_q[wr_ptr_q]  <= flt_pend_q ? '0 : mem_rdata;
      epc_q[wr_ptr_q]   <= flt_pend_q ? flt_pc_q : infl_pc_q;
      lane_q[wr_ptr_q]  <= flt_pend_q ? lane_t'(LANES - 1) : infl_lane_q;
      fault_q[wr_ptr_q] <= flt_pend_q;
    end
    if (reset_n && !redirect_valid && xfer_s && !pop_s) begin
      lane_q[rd_ptr_q] <= head_lane_s + lane_t'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: a bench-side ROM model predicts the instruction stream
// after each reset/redirect; transfers are popped and compared on the falling edge.
module tb_ifetch_buffer;

  logic        clk;
  logic        reset_n;
  logic [7:0]  mem_addr;
  logic [63:0] mem_rdata;
  logic        redirect_valid;
  logic [10:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [10:0] out_pc;
  logic        out_fault;

  ifetch_buffer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  typedef struct packed {
    logic [10:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic [63:0] rom [256];
  exp_t        sb_q [$];
  bit          sb_en;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= rom[mem_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_at(input logic [10:0] pc);
    logic [63:0] w;
    w = rom[pc[10:3]];
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic expect_stream(input logic [10:0] start, input int n);
    logic [10:0] p;
    exp_t e;
    p = start & 11'h7FC;
    for (int i = 0; i < n; i++) begin
      e.pc    = p;
      e.instr = instr_at(p);
      sb_q.push_back(e);
      p = p + 11'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [10:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc();
    redirect_valid = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < max);
    check_eq(tag, {63'd0, out_valid}, 64'd1);
  endtask

  // Scoreboard: every accepted instruction must match the predicted stream
  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_pc", {53'd0, out_pc}, {53'd0, e.pc});
        check_eq("sb_instr", {32'd0, out_instr}, {32'd0, e.instr});
        check_eq("sb_fault", {63'd0, out_fault}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] head_word;
    n_checks       = 0;
    n_fail         = 0;
    sb_en          = 1'b0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 11'd0;
    out_ready      = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      rom[i] = {8'hA5, b, 16'h1111, 8'h5A, b, 16'h2222};
    end
    rom[0] = 64'h00100093_00000013;
    rom[1] = 64'h00308193_00200113;

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_fault", {63'd0, out_fault}, 64'd0);
    check_eq("rst_pc", {53'd0, out_pc}, 64'd0);
    check_eq("rst_instr", {32'd0, out_instr}, 64'd0);
    check_eq("rst_addr", {56'd0, mem_addr}, 64'd0);

    // Reset release: two-cycle latency then the known boot sequence
    cyc();
    reset_n = 1'b1;
    expect_stream(11'h000, 64);
    sb_en = 1'b1;
    @(negedge clk);
    check_eq("lat_c0", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_eq("lat_c1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_eq("lat_c2", {63'd0, out_valid}, 64'd1);
    check_eq("boot0_pc", {53'd0, out_pc}, 64'h0);
    check_eq("boot0_instr", {32'd0, out_instr}, 64'h00000013);
    @(negedge clk);
    check_eq("boot1_pc", {53'd0, out_pc}, 64'h4);
    check_eq("boot1_instr", {32'd0, out_instr}, 64'h00100093);
    @(negedge clk);
    check_eq("boot2_pc", {53'd0, out_pc}, 64'h8);
    check_eq("boot2_instr", {32'd0, out_instr}, 64'h00200113);
    @(negedge clk);
    check_eq("boot3_pc", {53'd0, out_pc}, 64'hC);
    check_eq("boot3_instr", {32'd0, out_instr}, 64'h00308193);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("stream_nobubble", {63'd0, out_valid}, 64'd1);
    end

    // Backpressure: output holds, fetch stops with DEPTH words owned
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
      check_eq("stall_pc", {53'd0, out_pc}, {53'd0, sb_q[0].pc});
    end
    head_word = sb_q[0].pc[10:3];
    check_eq("stall_issue", {56'd0, mem_addr}, {56'd0, head_word + 8'd4});
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("release_nobubble", {63'd0, out_valid}, 64'd1);
    end

    // Redirect into lane 1 of a word while the FIFO is partly full
    cyc();
    out_ready = 1'b0;
    repeat (2) cyc();
    do_redirect(11'h014);
    expect_stream(11'h014, 32);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("redir_gap", {63'd0, out_valid}, 64'd0);
    wait_valid("redir_timeout", 6);
    check_eq("redir_pc0", {53'd0, out_pc}, 64'h14);
    @(negedge clk);
    check_eq("redir_pc1", {53'd0, out_pc}, 64'h18);

    // Word-address wrap at the top of memory
    cyc();
    do_redirect(11'h7F8);
    expect_stream(11'h7F8, 16);
    @(negedge clk);
    check_eq("wrap_addr_top", {56'd0, mem_addr}, 64'hFF);
    @(negedge clk);
    check_eq("wrap_addr_zero", {56'd0, mem_addr}, 64'h00);
    wait_valid("wrap_timeout", 6);
    check_eq("wrap_pc0", {53'd0, out_pc}, 64'h7F8);
    @(negedge clk);
    check_eq("wrap_pc1", {53'd0, out_pc}, 64'h7FC);
    @(negedge clk);
    check_eq("wrap_pc2", {53'd0, out_pc}, 64'h000);
    check_eq("wrap_instr2", {32'd0, out_instr}, 64'h00000013);

    // Back-to-back redirects: last one wins
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 11'h100;
    cyc();
    redirect_pc    = 11'h040;
    cyc();
    redirect_valid = 1'b0;
    sb_q.delete();
    expect_stream(11'h040, 16);
    wait_valid("b2b_timeout", 6);
    check_eq("b2b_pc", {53'd0, out_pc}, 64'h40);

    // Misaligned redirect
    cyc();
`ifdef IFETCH_MISALIGN_FAULT_EN
    sb_en = 1'b0;
    do_redirect(11'h022);
    @(negedge clk);
    check_eq("mis_gap", {63'd0, out_valid}, 64'd0);
    wait_valid("mis_timeout", 6);
    check_eq("mis_fault", {63'd0, out_fault}, 64'd1);
    check_eq("mis_pc", {53'd0, out_pc}, 64'h22);
    check_eq("mis_instr", {32'd0, out_instr}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("mis_idle_valid", {63'd0, out_valid}, 64'd0);
      check_eq("mis_idle_addr", {56'd0, mem_addr}, 64'h4);
    end
    cyc();
    do_redirect(11'h000);
    expect_stream(11'h000, 16);
    sb_en = 1'b1;
    wait_valid("mis_resume_timeout", 6);
    check_eq("mis_resume_pc", {53'd0, out_pc}, 64'h0);
`else
    do_redirect(11'h022);
    expect_stream(11'h022, 16);
    wait_valid("mis_timeout", 6);
    check_eq("mis_masked_pc", {53'd0, out_pc}, 64'h20);
    check_eq("mis_fault", {63'd0, out_fault}, 64'd0);
`endif

    // One-cycle reset mid-stream
    repeat (3) cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    sb_q.delete();
    expect_stream(11'h000, 32);
    @(negedge clk);
    check_eq("midrst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_pc", {53'd0, out_pc}, 64'd0);
    @(negedge clk);
    check_eq("midrst_valid1", {63'd0, out_valid}, 64'd0);
    wait_valid("midrst_timeout", 6);
    check_eq("midrst_first_pc", {53'd0, out_pc}, 64'h0);
    check_eq("midrst_first_instr", {32'd0, out_instr}, 64'h00000013);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
